// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake between a producer and the UART transmitter FIFO.
interface uart_tx_fifo_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO. A full block of bytes
// can be queued in one burst; frames then go out back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUDRATE   = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               wr,
    output logic                        data_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUDRATE;
    localparam int unsigned BAUD_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              baud_done;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;

    // Ready is derived from the registered count, so it behaves like a flop.
    assign wr.data_in_ready = (count != FULL_CNT);
    assign fifo_count       = count;

    // Handshake qualifiers and the pop decision shared by FIFO and FSM.
    always_comb begin
        fifo_empty = (count == '0);
        baud_done  = (baud_cnt == BAUD_LAST);
        push       = wr.data_in_valid && wr.data_in_ready;
        pop        = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (state == STOP && baud_done) begin
                pop = 1'b1;
            end
        end
    end

    // Byte storage; contents need no reset since pointers/count gate access.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr.data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_tx   <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_tx  <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        data_tx   <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        data_tx  <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            data_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            // Next bit is taken from index 1 because the shift lands this same edge.
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            data_tx   <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            data_tx   <= 1'b0;
                            state     <= START;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    data_tx <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: accepted bytes go into a scoreboard queue; an
// independent line monitor decodes 8N1 frames and compares against it.
module tb_uart_tx_fifo;

    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned BAUDRATE   = 100_000;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_tx;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUDRATE  (BAUDRATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (bus),
        .data_tx   (data_tx),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    logic [7:0] exp_q[$];
    int        pushes = 0;
    int        starts = 0;
    logic      rst_q = 1'b1;
    int        peak_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accepted-byte tracker: values read here are the pre-edge values.
    initial begin
        forever begin
            @(posedge clk);
            rst_q = rst;
            if (rst) begin
                pushes = 0;
                exp_q.delete();
            end else if (bus.data_in_valid && bus.data_in_ready) begin
                exp_q.push_back(bus.data_in);
                pushes++;
            end
        end
    end

    // Line monitor: UART receiver sampling mid-bit, plus occupancy/busy model.
    initial begin
        bit        in_frame = 1'b0;
        bit        gap_expect = 1'b0;
        int        k = 0;
        logic [7:0] rx = '0;
        logic [7:0] want;
        int        model_cnt;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                in_frame   = 1'b0;
                gap_expect = 1'b0;
                starts     = 0;
                check("rst_data_tx", 32'(data_tx), 32'd1);
                check("rst_tx_busy", 32'(tx_busy), 32'd0);
                check("rst_ready", 32'(bus.data_in_ready), 32'd1);
                check("rst_fifo_count", 32'(fifo_count), 32'd0);
                continue;
            end
            if (!in_frame) begin
                if (gap_expect) begin
                    check("no_gap_start", 32'(data_tx), 32'd0);
                end
                gap_expect = 1'b0;
                if (data_tx == 1'b0) begin
                    in_frame = 1'b1;
                    k        = 0;
                    rx       = '0;
                    starts++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end
                end
            end else begin
                k++;
                if (k == 5) begin
                    check("start_bit", 32'(data_tx), 32'd0);
                end
                if (k >= 15 && k <= 85 && (k - 15) % 10 == 0) begin
                    rx[(k - 15) / 10] = data_tx;
                end
                if (k == 95) begin
                    check("stop_bit", 32'(data_tx), 32'd1);
                    if (exp_q.size() > 0) begin
                        want = exp_q.pop_front();
                        check("rx_byte", 32'(rx), 32'(want));
                    end
                end
            end
            model_cnt = pushes - starts;
            if (32'(fifo_count) > 32'(peak_count)) peak_count = int'(fifo_count);
            check("fifo_count", 32'(fifo_count), 32'(model_cnt));
            check("ready", 32'(bus.data_in_ready), 32'(model_cnt < int'(FIFO_DEPTH)));
            check("tx_busy", 32'(tx_busy), 32'(in_frame));
            if (in_frame && k == 99) begin
                in_frame   = 1'b0;
                gap_expect = (model_cnt > 0);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.data_in       = b;
        bus.data_in_valid = 1'b1;
        for (int t = 0; t < 5000; t++) begin
            @(posedge clk);
            if (bus.data_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        bus.data_in_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_line_idle", 32'(data_tx), 32'd1);
        check("reset_count", 32'(fifo_count), 32'd0);

        // Single byte: start bit appears on the edge after acceptance.
        repeat (2) @(posedge clk);
        #1;
        push_byte(8'hA5);
        @(posedge clk);
        #1;
        check("latency_line_low", 32'(data_tx), 32'd0);
        check("latency_busy", 32'(tx_busy), 32'd1);
        repeat (99) @(posedge clk);
        #1;
        check("busy_last_cycle", 32'(tx_busy), 32'd1);
        @(posedge clk);
        #1;
        check("busy_cleared", 32'(tx_busy), 32'd0);
        drain();

        // Burst with valid held high until the FIFO back-pressures.
        peak_count = 0;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(i));
        end
        check("burst_peak_full", 32'(peak_count), 32'(FIFO_DEPTH));
        drain();

        // Back-to-back frames with no idle gap.
        push_byte(8'h01);
        push_byte(8'h80);
        push_byte(8'hFF);
        drain();

        // Reset in the middle of a frame with bytes still queued.
        push_byte(8'h3C);
        push_byte(8'hC3);
        push_byte(8'h5A);
        repeat (43) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_line_high", 32'(data_tx), 32'd1);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (data_tx !== 1'b1) begin
                check("midrst_no_frame", 32'(data_tx), 32'd1);
                break;
            end
        end

        // Randomised traffic with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 30)) @(posedge clk);
            if ($urandom_range(0, 9) == 0) repeat (120) @(posedge clk);
            #1;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
